// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Main control FSM for the multicycle RV32I core. Steps the shared ALU,
// memory, instruction register and register file through several cycles per
// instruction. It drives the ALUOp code for the downstream ALU decoder, every
// datapath mux select and every write enable. It also resolves branch
// conditions from the ALU flags.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous, active-high reset
//   opcode     in   [6:0]  instr[6:0] from IR
//   func3      in   [2:0]  instr[14:12] from IR
//   zero       in   ALU result == 0 (combinational from ALU)
//   neg        in   ALU signed less-than flag (combinational)
//   PCWrite    out  PC load enable (Mealy in BRANCH)
//   AdrSrc     out  memory address: 0=PC, 1=ALUOut
//   MemWrite   out  data memory write enable
//   IRWrite    out  IR and OldPC load enable
//   ResultSrc  out  [1:0] 00=ALUOut, 01=MDR, 10=ALUResult
//   ALUSrcA    out  [1:0] 00=PC, 01=OldPC, 10=rs1, 11=zero
//   ALUSrcB    out  [1:0] 00=rs2, 01=ImmExt, 10=constant 4
//   ALUOp      out  [1:0] 00=add, 01=sub, 10=by func3
//   RegWrite   out  register file write enable
//
// State table
//   state    | meaning
//   FETCH    | read instr at PC into IR/OldPC, PC <= PC+4
//   DECODE   | ALUOut <= OldPC+imm (branch/jal target), dispatch on opcode
//   MEMADR   | ALUOut <= rs1+imm (load/store address)
//   MEMREAD  | read data memory at ALUOut into MDR
//   MEMWB    | rd <= MDR
//   MEMWRITE | write rs2 to data memory at ALUOut
//   EXECR    | ALUOut <= rs1 op rs2
//   EXECI    | ALUOut <= rs1 op imm
//   LUI      | ALUOut <= 0+imm
//   ALUWB    | rd <= ALUOut
//   BRANCH   | compare rs1-rs2, PC <= ALUOut if taken
//   JAL      | PC <= ALUOut (target), ALUOut <= OldPC+4 (link)
//   JALRT    | ALUOut <= rs1+imm (jalr target)
//   JALRPC   | PC <= ALUOut (target), ALUOut <= OldPC+4 (link)
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       neg,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite
);

  // Opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Branch func3 codes
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // Mux select encodings
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_F3   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_LUI      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALRT    = 4'd12,
    S_JALRPC   = 4'd13
  } state_t;

  state_t state, state_nxt;

  logic branch_taken;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Branch condition: only the four supported compares can ever be taken.
  // The ALU is doing rs1-rs2 in BRANCH, so zero means equal and neg means
  // signed less-than.
  // ---------------------------------------------------------------------------
  always_comb begin
    branch_taken = 1'b0;
    unique case (func3)
      F3_BEQ:  branch_taken = zero;
      F3_BNE:  branch_taken = ~zero;
      F3_BLT:  branch_taken = neg;
      F3_BGE:  branch_taken = ~neg;
      default: branch_taken = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = S_FETCH;
    unique case (state)
      S_FETCH: state_nxt = S_DECODE;

      S_DECODE: begin
        unique case (opcode)
          OP_LOAD,
          OP_STORE:  state_nxt = S_MEMADR;
          OP_RTYPE:  state_nxt = S_EXECR;
          OP_IALU:   state_nxt = S_EXECI;
          OP_BRANCH: state_nxt = S_BRANCH;
          OP_JAL:    state_nxt = S_JAL;
          OP_JALR:   state_nxt = S_JALRT;
          OP_LUI:    state_nxt = S_LUI;
          // Unknown opcodes retire as a nop without touching any state.
          default:   state_nxt = S_FETCH;
        endcase
      end

      S_MEMADR:   state_nxt = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_nxt = S_MEMWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = S_FETCH;
      S_EXECR:    state_nxt = S_ALUWB;
      S_EXECI:    state_nxt = S_ALUWB;
      S_LUI:      state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_JAL:      state_nxt = S_ALUWB;
      S_JALRT:    state_nxt = S_JALRPC;
      S_JALRPC:   state_nxt = S_ALUWB;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    RegWrite  = 1'b0;

    unique case (state)
      S_FETCH: begin
        AdrSrc    = 1'b0;
        IRWrite   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ALUOp     = ALUOP_ADD;
        ResultSrc = RES_ALURES;
        PCWrite   = 1'b1;
      end

      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end

      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end

      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
      end

      S_MEMWB: begin
        ResultSrc = RES_MDR;
        RegWrite  = 1'b1;
      end

      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        MemWrite  = 1'b1;
      end

      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_F3;
      end

      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_F3;
      end

      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end

      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
      end

      S_BRANCH: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        PCWrite   = branch_taken;
      end

      // JAL and JALRPC share one datapath shape: PC takes the target held in
      // ALUOut while the ALU forms OldPC+4 as the link value for ALUWB.
      S_JAL,
      S_JALRPC: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ALUOp     = ALUOP_ADD;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
      end

      S_JALRT: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end

      default: begin
        PCWrite = 1'b0;
      end
    endcase

    // Reset wins over the decode: no strobe may fire while rst is high, even
    // if it arrives mid-instruction, and the selects park at FETCH values.
    if (rst) begin
      PCWrite   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = RES_ALURES;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_FOUR;
      ALUOp     = ALUOP_ADD;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for multicycle_controller. Outputs are packed into one
// 13-bit word {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
// ALUSrcB, ALUOp, RegWrite} and compared with hand-written per-state words.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       zero;
  logic       neg;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       RegWrite;

  int compared;
  int mismatched;

  //                          PCW Adr MW IRW RS  SA  SB  OP  RW
  localparam logic [12:0] E_RESET    = 13'b0_0_0_0_10_00_10_00_0;
  localparam logic [12:0] E_FETCH    = 13'b1_0_0_1_10_00_10_00_0;
  localparam logic [12:0] E_DECODE   = 13'b0_0_0_0_00_01_01_00_0;
  localparam logic [12:0] E_MEMADR   = 13'b0_0_0_0_00_10_01_00_0;
  localparam logic [12:0] E_MEMREAD  = 13'b0_1_0_0_00_00_00_00_0;
  localparam logic [12:0] E_MEMWB    = 13'b0_0_0_0_01_00_00_00_1;
  localparam logic [12:0] E_MEMWRITE = 13'b0_1_1_0_00_00_00_00_0;
  localparam logic [12:0] E_EXECR    = 13'b0_0_0_0_00_10_00_10_0;
  localparam logic [12:0] E_EXECI    = 13'b0_0_0_0_00_10_01_10_0;
  localparam logic [12:0] E_LUI      = 13'b0_0_0_0_00_11_01_00_0;
  localparam logic [12:0] E_ALUWB    = 13'b0_0_0_0_00_00_00_00_1;
  localparam logic [12:0] E_BR_TAKEN = 13'b1_0_0_0_00_10_00_01_0;
  localparam logic [12:0] E_BR_NOT   = 13'b0_0_0_0_00_10_00_01_0;
  localparam logic [12:0] E_JAL      = 13'b1_0_0_0_00_01_10_00_0;
  localparam logic [12:0] E_JALRT    = 13'b0_0_0_0_00_10_01_00_0;

  multicycle_controller dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .func3     (func3),
    .zero      (zero),
    .neg       (neg),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .RegWrite  (RegWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, RegWrite};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst    = 1'b1;
    opcode = 7'b0110011;
    func3  = 3'b000;
    zero   = 1'b0;
    neg    = 1'b0;

    // Reset held for two edges
    adv(); chk("reset_c1", E_RESET);
    adv(); chk("reset_c2", E_RESET);
    rst = 1'b0;
    #1 chk("fetch_after_reset", E_FETCH);

    // R-type: 4 cycles
    adv(); chk("r_decode", E_DECODE);
    adv(); chk("r_execr", E_EXECR);
    adv(); chk("r_aluwb", E_ALUWB);
    adv(); chk("r_fetch_c5", E_FETCH);

    // lw: 5 cycles
    opcode = 7'b0000011;
    adv(); chk("lw_decode", E_DECODE);
    adv(); chk("lw_memadr", E_MEMADR);
    adv(); chk("lw_memread", E_MEMREAD);
    adv(); chk("lw_memwb", E_MEMWB);
    adv(); chk("lw_fetch", E_FETCH);

    // sw: 4 cycles
    opcode = 7'b0100011;
    adv(); chk("sw_decode", E_DECODE);
    adv(); chk("sw_memadr", E_MEMADR);
    adv(); chk("sw_memwrite", E_MEMWRITE);
    adv(); chk("sw_fetch", E_FETCH);

    // I-ALU
    opcode = 7'b0010011;
    adv(); chk("i_decode", E_DECODE);
    adv(); chk("i_execi", E_EXECI);
    adv(); chk("i_aluwb", E_ALUWB);
    adv(); chk("i_fetch", E_FETCH);

    // lui
    opcode = 7'b0110111;
    adv(); chk("lui_decode", E_DECODE);
    adv(); chk("lui_lui", E_LUI);
    adv(); chk("lui_aluwb", E_ALUWB);
    adv(); chk("lui_fetch", E_FETCH);

    // beq, zero=1 -> taken; Mealy output follows zero within the cycle
    opcode = 7'b1100011; func3 = 3'b000; zero = 1'b1; neg = 1'b0;
    adv(); chk("beq_decode", E_DECODE);
    adv(); chk("beq_z1_taken", E_BR_TAKEN);
    zero = 1'b0;
    #1 chk("beq_z0_not", E_BR_NOT);
    adv(); chk("beq_fetch", E_FETCH);

    // bne, zero=1 -> not taken; zero=0 -> taken
    func3 = 3'b001; zero = 1'b1;
    adv(); chk("bne_decode", E_DECODE);
    adv(); chk("bne_z1_not", E_BR_NOT);
    zero = 1'b0;
    #1 chk("bne_z0_taken", E_BR_TAKEN);
    adv(); chk("bne_fetch", E_FETCH);

    // blt, neg=1 -> taken
    func3 = 3'b100; neg = 1'b1; zero = 1'b0;
    adv(); chk("blt_decode", E_DECODE);
    adv(); chk("blt_n1_taken", E_BR_TAKEN);
    neg = 1'b0;
    #1 chk("blt_n0_not", E_BR_NOT);
    adv(); chk("blt_fetch", E_FETCH);

    // bge, neg=0 -> taken; neg=1 -> not taken
    func3 = 3'b101; neg = 1'b0;
    adv(); chk("bge_decode", E_DECODE);
    adv(); chk("bge_n0_taken", E_BR_TAKEN);
    neg = 1'b1;
    #1 chk("bge_n1_not", E_BR_NOT);
    adv(); chk("bge_fetch", E_FETCH);

    // unsupported func3 010 -> never taken regardless of flags
    func3 = 3'b010; zero = 1'b1; neg = 1'b1;
    adv(); chk("b010_decode", E_DECODE);
    adv(); chk("b010_z1n1_not", E_BR_NOT);
    zero = 1'b0; neg = 1'b0;
    #1 chk("b010_z0n0_not", E_BR_NOT);
    adv(); chk("b010_fetch", E_FETCH);

    // jal
    opcode = 7'b1101111; zero = 1'b0; neg = 1'b0; func3 = 3'b000;
    adv(); chk("jal_decode", E_DECODE);
    adv(); chk("jal_jal", E_JAL);
    adv(); chk("jal_aluwb", E_ALUWB);
    adv(); chk("jal_fetch", E_FETCH);

    // jalr: 5 cycles
    opcode = 7'b1100111;
    adv(); chk("jalr_decode", E_DECODE);
    adv(); chk("jalr_jalrt", E_JALRT);
    adv(); chk("jalr_jalrpc", E_JAL);
    adv(); chk("jalr_aluwb", E_ALUWB);
    adv(); chk("jalr_fetch", E_FETCH);

    // unknown opcode: 2 cycles, no strobes in DECODE
    opcode = 7'b1111111;
    adv(); chk("unk_decode", E_DECODE);
    adv(); chk("unk_fetch", E_FETCH);

    // reset asserted during MEMWRITE kills the write, FETCH follows
    opcode = 7'b0100011;
    adv(); chk("rsw_decode", E_DECODE);
    adv(); chk("rsw_memadr", E_MEMADR);
    adv(); chk("rsw_memwrite", E_MEMWRITE);
    rst = 1'b1;
    #1 chk("rsw_rst_in_memwrite", E_RESET);
    adv(); chk("rsw_rst_held", E_RESET);
    rst = 1'b0;
    #1 chk("rsw_fetch_after", E_FETCH);
    adv(); chk("rsw_decode2", E_DECODE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
